branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 16, the number of predictor entries (power of 2, 4..64).
REQ-002 The module SHALL have parameter IDX_W, default 4, equal to log2(ENTRIES).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The module SHALL have port fetch_valid, input, 1 bit: a lookup is requested this cycle.
REQ-006 The module SHALL have port fetch_pc, input, 32 bits: PC being fetched.
REQ-007 The module SHALL have port pred_valid, output, 1 bit: prediction outputs are valid.
REQ-008 The module SHALL have port pred_taken, output, 1 bit: branch predicted taken.
REQ-009 The module SHALL have port pred_target, output, 32 bits: predicted target PC.
REQ-010 The module SHALL have port upd_valid, input, 1 bit: a resolved branch is presented.
REQ-011 The module SHALL have port upd_pc, input, 32 bits: PC of the resolved branch.
REQ-012 The module SHALL have port upd_taken, input, 1 bit: resolved outcome, driven by the branch comparator enable.
REQ-013 The module SHALL have port upd_target, input, 32 bits: resolved taken target.
REQ-014 The module SHALL have port upd_pred_taken, input, 1 bit: the prediction made earlier for this branch.
REQ-015 The module SHALL have port upd_pred_target, input, 32 bits: the target predicted earlier for this branch.
REQ-016 The module SHALL have port mispredict, output, 1 bit: one-cycle pulse flagging a wrong prediction.
REQ-017 The module SHALL have port redirect_pc, output, 32 bits: the correct next PC, valid while mispredict=1.

Function
REQ-018 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[31:IDX_W+2]; pc[1:0] is ignored.
REQ-019 Each entry SHALL hold a 2-bit saturating counter, a BTB valid bit, a tag, and a 32-bit target.
REQ-020 Lookup latency SHALL be 1 cycle: pred_valid is the registered fetch_valid.
REQ-021 pred_taken SHALL be registered as valid & tag match & counter[1]; pred_target is the stored target when pred_taken=1, else fetch_pc+4.
REQ-022 When pred_valid=0, pred_taken SHALL be 0 and pred_target SHALL hold its previous value.
REQ-023 On upd_valid with upd_taken=1, the counter SHALL increment and saturate at 11.
REQ-024 On upd_valid with upd_taken=0, the counter SHALL decrement and saturate at 00.
REQ-025 On upd_valid with upd_taken=1 and a tag hit, the stored target SHALL be overwritten with upd_target.
REQ-026 On upd_valid with upd_taken=1 and a tag miss, the entry SHALL be replaced: valid=1, new tag, target=upd_target, counter=10.
REQ-027 On upd_valid with upd_taken=0 and a tag miss, the BTB fields SHALL be unchanged and only the counter updated.
REQ-028 When a lookup and an update hit the same index in one cycle, the lookup SHALL return pre-update state (no bypass).
REQ-029 mispredict SHALL pulse for exactly one cycle, the cycle after upd_valid, when upd_taken!=upd_pred_taken or (both are 1 and upd_target!=upd_pred_target).
REQ-030 When mispredict=1, redirect_pc SHALL equal upd_target if upd_taken=1, else upd_pc+4 (mod 2^32).
REQ-031 Back-to-back updates on consecutive cycles SHALL each be applied; no stall output exists.

Reset
REQ-032 While rst_n=0, all valid bits SHALL be 0, all counters SHALL be 01, and all outputs SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard any in-flight lookup or update; pred_valid and mispredict SHALL be 0 in the first cycle after release.

Configuration
REQ-034 When macro BP_STATS_EN is defined, the module SHALL add outputs stat_branches[15:0] and stat_mispredicts[15:0], counting upd_valid and mispredict events, saturating at 0xFFFF and cleared by reset.
REQ-035 When BP_STATS_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 After reset, lookup pc=0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
REQ-037 Update pc=0x100, taken, target=0x200, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x200; lookup 0x100 -> pred_taken=1, pred_target=0x200.
REQ-038 Three taken updates at 0x100 then two not-taken -> counter 11 then 01; lookup predicts not-taken; a 4th taken update does not exceed 11.
REQ-039 Update 0x140 taken (same index as 0x100, ENTRIES=16) -> lookup 0x100 misses: pred_taken=0.
REQ-040 Same-cycle lookup and update at 0x100 -> lookup returns the old prediction; the following lookup reflects the update.
REQ-041 With BP_STATS_EN defined, 5 updates of which 2 mispredict -> stat_branches=5, stat_mispredicts=2; rst_n pulse mid-sequence -> both 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with a tagged BTB; 1-cycle lookup, registered mispredict/redirect.
// Define BP_STATS_EN to add saturating branch/mispredict event counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
`ifdef BP_STATS_EN
  output logic [31:0] redirect_pc,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
`else
  output logic [31:0] redirect_pc
`endif
);
  localparam int TAG_W = 30 - IDX_W;

  logic [1:0]       cnt   [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [31:0]      tgt_q [ENTRIES];
  logic [ENTRIES-1:0] btb_vld;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_taken, u_hit, mis_c;

  assign f_idx   = fetch_pc[IDX_W+1:2];
  assign f_tag   = fetch_pc[31:IDX_W+2];
  assign u_idx   = upd_pc[IDX_W+1:2];
  assign u_tag   = upd_pc[31:IDX_W+2];
  assign f_taken = btb_vld[f_idx] && (tag_q[f_idx] == f_tag) && cnt[f_idx][1];
  assign u_hit   = btb_vld[u_idx] && (tag_q[u_idx] == u_tag);
  assign mis_c   = upd_valid && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && (upd_target != upd_pred_target)));

  // Table write; the lookup below reads the same registers, so a same-cycle
  // lookup naturally sees pre-update state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt[i]   <= 2'b01;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (u_hit) begin
          if (cnt[u_idx] != 2'b11) cnt[u_idx] <= cnt[u_idx] + 2'd1;
          tgt_q[u_idx] <= upd_target;
        end else begin
          btb_vld[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= upd_target;
          cnt[u_idx]     <= 2'b10;
        end
      end else if (cnt[u_idx] != 2'b00) begin
        cnt[u_idx] <= cnt[u_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      pred_valid <= fetch_valid;
      pred_taken <= fetch_valid && f_taken;
      if (fetch_valid) pred_target <= f_taken ? tgt_q[f_idx] : fetch_pc + 32'd4;
      mispredict <= mis_c;
      if (mis_c) redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
    end
  end

`ifdef BP_STATS_EN
  // Counters advance with the update itself, so both stay aligned in time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (mis_c && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized check of branch_predictor against a table-level reference model.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_valid, pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc;
  logic        upd_valid = 1'b0, upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict),
`ifdef BP_STATS_EN
    .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`else
    .redirect_pc(redirect_pc)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per table slot, counters as plain integers 0..3
  int          m_cnt [ENTRIES];
  bit          m_vld [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  logic        e_pv, e_pt, e_mis;
  logic [31:0] e_ptgt, e_redir;
  int          e_br, e_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_cnt[i] = 1; m_vld[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    e_pv = 0; e_pt = 0; e_ptgt = '0; e_mis = 0; e_redir = '0; e_br = 0; e_mp = 0;
  endtask

  task automatic idle_inputs();
    fetch_valid = 0; upd_valid = 0; upd_taken = 0; upd_pred_taken = 0;
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".pred_valid"}, 32'(pred_valid), 32'(e_pv));
    chk({ctx, ".pred_taken"}, 32'(pred_taken), 32'(e_pt));
    chk({ctx, ".pred_target"}, pred_target, e_ptgt);
    chk({ctx, ".mispredict"}, 32'(mispredict), 32'(e_mis));
    if (e_mis) chk({ctx, ".redirect_pc"}, redirect_pc, e_redir);
`ifdef BP_STATS_EN
    chk({ctx, ".stat_branches"}, 32'(stat_branches), 32'(e_br));
    chk({ctx, ".stat_mispredicts"}, 32'(stat_mispredicts), 32'(e_mp));
`endif
  endtask

  // Assert reset (called at a negedge), check outputs are cleared, release at a later negedge.
  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    #1;
    model_reset();
    chk("rst.pred_valid", 32'(pred_valid), 32'd0);
    chk("rst.pred_taken", 32'(pred_taken), 32'd0);
    chk("rst.pred_target", pred_target, 32'd0);
    chk("rst.mispredict", 32'(mispredict), 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'd0);
`ifdef BP_STATS_EN
    chk("rst.stat_branches", 32'(stat_branches), 32'd0);
    chk("rst.stat_mispredicts", 32'(stat_mispredicts), 32'd0);
`endif
    @(posedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: drive at negedge, model the edge, compare at the following negedge.
  task automatic step(input string ctx, input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    int  i;
    bit  hit, wrong;
    fetch_valid = fv; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt;
    @(posedge clk);
    e_pv = fv;
    if (fv) begin
      i = slot(fpc);
      hit = m_vld[i] && (m_tag[i] == tag_of(fpc));
      e_pt = hit && (m_cnt[i] >= 2);
      e_ptgt = e_pt ? m_tgt[i] : fpc + 32'd4;
    end else begin
      e_pt = 0;
    end
    wrong = uv && ((ut != upt) || (ut && utgt != uptgt));
    e_mis = wrong;
    if (wrong) e_redir = ut ? utgt : upc + 32'd4;
    if (uv) begin
      if (e_br < 16'hFFFF) e_br++;
      if (wrong && e_mp < 16'hFFFF) e_mp++;
      i = slot(upc);
      hit = m_vld[i] && (m_tag[i] == tag_of(upc));
      if (ut) begin
        if (hit) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = utgt;
        end else begin
          m_vld[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt; m_cnt[i] = 2;
        end
      end else begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end
    end
    @(negedge clk);
    check_outputs(ctx);
    idle_inputs();
  endtask

  task automatic fetch(input string ctx, input logic [31:0] pc);
    step(ctx, 1, pc, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic upd(input string ctx, input logic [31:0] pc, input logic t,
                     input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    step(ctx, 0, '0, 1, pc, t, tgt, pt, ptgt);
  endtask

  logic [31:0] pool [4] = '{32'h100, 32'h140, 32'h180, 32'h2C4};

  initial begin
    logic [31:0] fpc, upc, utgt, uptgt;
    logic        ut, upt;
    model_reset();
    @(negedge clk);
    do_reset();

    // Cold lookup misses and falls through
    fetch("cold", 32'h100);
    chk("cold.lit_target", pred_target, 32'h104);

    // First taken resolution allocates and mispredicts
    upd("alloc", 32'h100, 1, 32'h200, 0, 32'h0);
    chk("alloc.lit_redirect", redirect_pc, 32'h200);
    fetch("alloc_hit", 32'h100);
    chk("alloc_hit.lit_taken", 32'(pred_taken), 32'd1);

    // Saturation up, down, and no overshoot past strongly-taken
    for (int k = 0; k < 3; k++) upd("sat_up", 32'h100, 1, 32'h200, 1, 32'h200);
    fetch("sat_up_look", 32'h100);
    for (int k = 0; k < 2; k++) upd("sat_dn", 32'h100, 0, 32'h200, 1, 32'h200);
    fetch("weak_nt_look", 32'h100);
    chk("weak_nt.lit_taken", 32'(pred_taken), 32'd0);
    for (int k = 0; k < 4; k++) upd("sat_up2", 32'h100, 1, 32'h200, 1, 32'h200);
    upd("one_nt", 32'h100, 0, 32'h200, 1, 32'h200);
    fetch("no_overshoot", 32'h100);
    chk("no_overshoot.lit_taken", 32'(pred_taken), 32'd1);

    // Alias at same index replaces the entry
    upd("alias", 32'h140, 1, 32'h300, 0, 32'h0);
    fetch("alias_miss", 32'h100);
    chk("alias_miss.lit_taken", 32'(pred_taken), 32'd0);

    // Same-cycle lookup and update: lookup sees the old state
    step("same_cyc", 1, 32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h300);
    chk("same_cyc.lit_target", pred_target, 32'h300);
    fetch("after_same", 32'h140);

    // Not-taken redirect to fall-through, then back-to-back updates
    upd("nt_redir", 32'h180, 0, 32'h0, 1, 32'h500);
    chk("nt_redir.lit_redirect", redirect_pc, 32'h184);
    upd("b2b_a", 32'h1C0, 1, 32'h600, 1, 32'h600);
    upd("b2b_b", 32'h1C0, 1, 32'h604, 1, 32'h600);
    fetch("b2b_look", 32'h1C0);

    // Reset in the middle of a lookup + update
    fetch_valid = 1; fetch_pc = 32'h1C0;
    upd_valid = 1; upd_pc = 32'h1C0; upd_taken = 1; upd_target = 32'h700;
    upd_pred_taken = 0; upd_pred_target = 32'h0;
    #2;
    do_reset();
    @(posedge clk); @(negedge clk);
    chk("post_rst.pred_valid", 32'(pred_valid), 32'd0);
    chk("post_rst.mispredict", 32'(mispredict), 32'd0);
    fetch("post_rst_look", 32'h1C0);

    // Randomized traffic with a small PC pool to force hits and aliases
    for (int n = 0; n < 400; n++) begin
      fpc  = ($urandom % 4 != 0) ? (pool[$urandom % 4] | ($urandom % 4)) : $urandom;
      upc  = ($urandom % 4 != 0) ? (pool[$urandom % 4] | ($urandom % 4)) : $urandom;
      ut   = 1'($urandom % 2);
      upt  = 1'($urandom % 2);
      utgt = {$urandom % 8, 8'h00} + 32'h1000;
      uptgt = ($urandom % 2 != 0) ? utgt : $urandom;
      step("rand", 1'($urandom % 2), fpc, 1'($urandom % 3 != 0), upc, ut, utgt, upt, uptgt);
    end

`ifdef BP_STATS_EN
    do_reset();
    upd("st1", 32'h100, 1, 32'h200, 0, 32'h0);
    upd("st2", 32'h100, 1, 32'h200, 1, 32'h200);
    upd("st3", 32'h100, 0, 32'h0, 0, 32'h0);
    upd("st4", 32'h140, 0, 32'h0, 1, 32'h0);
    upd("st5", 32'h180, 0, 32'h0, 0, 32'h0);
    chk("stats.lit_branches", 32'(stat_branches), 32'd5);
    chk("stats.lit_mispredicts", 32'(stat_mispredicts), 32'd2);
    do_reset();
    fetch("stats_cleared", 32'h100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
